// File: rtl/neighbor_fetch_if.sv
// Request, board-read and tile_check signals of neighbor_fetch in one bundle.
// The master modport is the fetch unit; the slave modport is its environment.
interface neighbor_fetch_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic                 req;
  logic [RW-1:0]        row;
  logic [CW-1:0]        col;
  logic                 mem_en;
  logic [RW+CW-1:0]     mem_addr;
  logic [11:0]          mem_rdata;
  logic [2:0]           up_tile;
  logic [2:0]           down_tile;
  logic [2:0]           right_tile;
  logic [2:0]           left_tile;
  logic                 start_signal;
  logic                 endsignal;
  logic [5:0]           tile_type;
  logic [5:0]           result_type;
  logic                 done;
  logic                 error;
  logic                 busy;

  modport master (
    input  req, row, col, mem_rdata, endsignal, tile_type,
    output mem_en, mem_addr, up_tile, down_tile, right_tile, left_tile,
           start_signal, result_type, done, error, busy
  );

  modport slave (
    output req, row, col, mem_rdata, endsignal, tile_type,
    input  mem_en, mem_addr, up_tile, down_tile, right_tile, left_tile,
           start_signal, result_type, done, error, busy
  );
endinterface

// File: rtl/neighbor_fetch.sv
// Reads a target cell and its four neighbours from the board, hands the facing
// edge codes to tile_check and returns its verdict with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for req
// SELF  | read target cell
// UP    | read row-1, capture target word
// DOWN  | read row+1, capture up neighbour
// RIGHT | read col+1, capture down neighbour
// LEFT  | read col-1, capture right neighbour
// CAP   | capture left neighbour, decide occupied vs check
// CHECK | start_signal high, wait for endsignal
// DONE  | done pulse with error
module neighbor_fetch #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  neighbor_fetch_if.master  bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [3:0] {
    IDLE, SELF, UP, DOWN, RIGHT, LEFT, CAP, CHECK, DONE
  } state_t;

  state_t        state;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [11:0]   self_word;
  logic          at_top, at_bot, at_left, at_right;

  assign at_top   = (row_q == '0);
  assign at_bot   = (row_q == RW'(ROWS - 1));
  assign at_left  = (col_q == '0);
  assign at_right = (col_q == CW'(COLS - 1));

  // Outputs are registered, so each read slot's address is set on entry to it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      row_q            <= '0;
      col_q            <= '0;
      self_word        <= '0;
      bus.mem_en       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.up_tile      <= 3'b000;
      bus.down_tile    <= 3'b000;
      bus.right_tile   <= 3'b000;
      bus.left_tile    <= 3'b000;
      bus.start_signal <= 1'b0;
      bus.result_type  <= 6'd0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            row_q        <= bus.row;
            col_q        <= bus.col;
            bus.mem_en   <= 1'b1;
            bus.mem_addr <= {bus.row, bus.col};
            bus.busy     <= 1'b1;
            state        <= SELF;
          end
        end
        SELF: begin
          bus.mem_en   <= !at_top;
          bus.mem_addr <= {row_q - 1'b1, col_q};
          state        <= UP;
        end
        UP: begin
          self_word    <= bus.mem_rdata;
          bus.mem_en   <= !at_bot;
          bus.mem_addr <= {row_q + 1'b1, col_q};
          state        <= DOWN;
        end
        DOWN: begin
          bus.up_tile  <= at_top ? 3'b000 : bus.mem_rdata[5:3];
          bus.mem_en   <= !at_right;
          bus.mem_addr <= {row_q, col_q + 1'b1};
          state        <= RIGHT;
        end
        RIGHT: begin
          bus.down_tile <= at_bot ? 3'b000 : bus.mem_rdata[11:9];
          bus.mem_en    <= !at_left;
          bus.mem_addr  <= {row_q, col_q - 1'b1};
          state         <= LEFT;
        end
        LEFT: begin
          bus.right_tile <= at_right ? 3'b000 : bus.mem_rdata[2:0];
          bus.mem_en     <= 1'b0;
          state          <= CAP;
        end
        CAP: begin
          bus.left_tile <= at_left ? 3'b000 : bus.mem_rdata[8:6];
          if (self_word != 12'd0) begin
            bus.result_type <= 6'd0;
            bus.done        <= 1'b1;
            bus.error       <= 1'b1;
            state           <= DONE;
          end else begin
            bus.start_signal <= 1'b1;
            state            <= CHECK;
          end
        end
        CHECK: begin
          if (bus.endsignal) begin
            bus.result_type  <= bus.tile_type;
            bus.start_signal <= 1'b0;
            bus.done         <= 1'b1;
            bus.error        <= (bus.tile_type == 6'd0);
            state            <= DONE;
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.error <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neighbor_fetch.sv
// Randomized bench for neighbor_fetch: board memory, tile_check responder and a
// reference model that derives expected edges and timing from the board array.
module tb_neighbor_fetch;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  neighbor_fetch_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
  neighbor_fetch #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  logic [11:0] board [ROWS][COLS];
  int n_tests = 0;
  int n_fail  = 0;

  // Synchronous-read board; bus carries junk whenever no read was issued.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= board[bus.mem_addr[5:3]][bus.mem_addr[2:0]];
    else            bus.mem_rdata <= 12'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) board[r][c] = 12'd0;
  endtask

  task automatic run_txn(input int r, input int c, input int k,
                         input logic [5:0] ttype, input bit inject);
    logic [2:0] exp_up, exp_down, exp_right, exp_left;
    bit occupied;
    int exp_done, first_start, start_cnt, done_at;
    logic [5:0] exp_res, got_res;
    logic exp_err, got_err;
    logic en [1:5];
    logic [5:0] ad [1:5];
    logic exp_en [1:5];
    logic [5:0] exp_ad [1:5];
    bit busy_ok;

    exp_up    = (r > 0)        ? board[r-1][c][5:3]  : 3'b000;
    exp_down  = (r < ROWS - 1) ? board[r+1][c][11:9] : 3'b000;
    exp_right = (c < COLS - 1) ? board[r][c+1][2:0]  : 3'b000;
    exp_left  = (c > 0)        ? board[r][c-1][8:6]  : 3'b000;
    occupied  = (board[r][c] != 12'd0);
    exp_done  = occupied ? 7 : 8 + k;
    exp_res   = occupied ? 6'd0 : ttype;
    exp_err   = occupied || (ttype == 6'd0);
    exp_en[1] = 1'b1;            exp_ad[1] = {3'(r),     3'(c)};
    exp_en[2] = (r > 0);         exp_ad[2] = {3'(r - 1), 3'(c)};
    exp_en[3] = (r < ROWS - 1);  exp_ad[3] = {3'(r + 1), 3'(c)};
    exp_en[4] = (c < COLS - 1);  exp_ad[4] = {3'(r),     3'(c + 1)};
    exp_en[5] = (c > 0);         exp_ad[5] = {3'(r),     3'(c - 1)};

    first_start = -1; start_cnt = 0; done_at = -1; busy_ok = 1;
    got_res = '0; got_err = 1'b0;

    @(negedge clk);
    bus.req = 1'b1; bus.row = 3'(r); bus.col = 3'(c);
    for (int j = 1; j <= 60 && done_at < 0; j++) begin
      @(negedge clk);
      if (j <= 5) begin en[j] = bus.mem_en; ad[j] = bus.mem_addr; end
      if (bus.start_signal) begin
        start_cnt++;
        if (first_start < 0) first_start = j;
      end
      if (!bus.busy) busy_ok = 0;
      if (bus.done) begin done_at = j; got_err = bus.error; got_res = bus.result_type; end
      bus.req       = inject && (j == 3 || j == exp_done);
      bus.row       = 3'($urandom);
      bus.col       = 3'($urandom);
      bus.endsignal = (j == 3) || (!occupied && j == 7 + k);
      bus.tile_type = (j == 7 + k) ? ttype : 6'($urandom);
    end

    chk("done_cycle", done_at, exp_done);
    chk("error", got_err, exp_err);
    chk("result_at_done", got_res, exp_res);
    chk("start_first", first_start, occupied ? -1 : 7);
    chk("start_cycles", start_cnt, occupied ? 0 : k + 1);
    chk("busy_until_done", busy_ok, 1);
    for (int j = 1; j <= 5; j++) begin
      chk($sformatf("mem_en_slot%0d", j), en[j], exp_en[j]);
      if (exp_en[j]) chk($sformatf("mem_addr_slot%0d", j), ad[j], exp_ad[j]);
    end

    @(negedge clk);
    bus.req = 1'b0; bus.endsignal = 1'b0;
    chk("done_one_cycle", bus.done, 0);
    chk("idle_after_done", bus.busy, 0);
    chk("up_tile", bus.up_tile, exp_up);
    chk("down_tile", bus.down_tile, exp_down);
    chk("right_tile", bus.right_tile, exp_right);
    chk("left_tile", bus.left_tile, exp_left);
    chk("result_hold", bus.result_type, exp_res);
  endtask

  initial begin
    bus.req = 1'b0; bus.row = '0; bus.col = '0;
    bus.endsignal = 1'b0; bus.tile_type = '0;
    clear_board();

    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_start", bus.start_signal, 0);
    chk("rst_tiles", {bus.up_tile, bus.down_tile, bus.right_tile, bus.left_tile}, 0);
    chk("rst_result", bus.result_type, 0);
    reset_n = 1'b1;

    // Up neighbour of (3,3) faces down with code 001.
    board[2][3] = 12'b000_000_001_000;
    run_txn(3, 3, 2, 6'h05, 1'b0);

    // Corner (0,0): right neighbour left_e=110, down neighbour up_e=010.
    clear_board();
    board[0][1] = 12'b000_000_000_110;
    board[1][0] = 12'b010_000_000_000;
    run_txn(0, 0, 1, 6'h11, 1'b0);

    clear_board();
    board[4][4] = 12'h249;
    run_txn(4, 4, 0, 6'h03, 1'b1);

    clear_board();
    run_txn(5, 5, 4, 6'h00, 1'b0);

    for (int t = 0; t < 25; t++) begin
      int r, c;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          board[i][j] = ($urandom_range(0, 1) == 0) ? 12'd0 : 12'($urandom);
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      if ($urandom_range(0, 9) < 7) board[r][c] = 12'd0;
      run_txn(r, c, $urandom_range(0, 6), 6'($urandom), 1'($urandom));
    end

    // Reset landing on the same edge as endsignal in CHECK.
    clear_board();
    board[2][3] = 12'b000_000_011_000;
    @(negedge clk);
    bus.req = 1'b1; bus.row = 3'd3; bus.col = 3'd3;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      bus.req = 1'b0;
    end
    chk("mid_check_start", bus.start_signal, 1);
    reset_n = 1'b0; bus.endsignal = 1'b1; bus.tile_type = 6'h2a;
    @(negedge clk);
    reset_n = 1'b1; bus.endsignal = 1'b0;
    chk("rst_chk_busy", bus.busy, 0);
    chk("rst_chk_done", bus.done, 0);
    chk("rst_chk_start", bus.start_signal, 0);
    chk("rst_chk_result", bus.result_type, 0);
    chk("rst_chk_up", bus.up_tile, 0);
    begin
      int saw_done = 0;
      repeat (10) begin
        @(negedge clk);
        if (bus.done || bus.busy) saw_done = 1;
      end
      chk("rst_chk_quiet", saw_done, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
